// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Holds the FSM state encoding and the bit-counter width helper.
// Imported by the serializer top level.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width of the bit counter for a given word width. The lower bound of 1
  // keeps the counter at least one bit wide.
  function automatic int bit_cnt_width(input int data_width);
    return (data_width <= 2) ? 1 : $clog2(data_width);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-input handshake bundle for the serializer.
// Signals: s_valid_i/s_ready_o handshake; s_data_i word; msb_first_i bit order;
//          clk_div_i bit period (cycles per bit minus one).
interface piso_serializer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 8
);
  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  msb_first_i;
  logic [DIV_WIDTH-1:0]  clk_div_i;

  // Producer side.
  modport master (
    output s_valid_i,
    output s_data_i,
    output msb_first_i,
    output clk_div_i,
    input  s_ready_o
  );

  // Serializer side.
  modport slave (
    input  s_valid_i,
    input  s_data_i,
    input  msb_first_i,
    input  clk_div_i,
    output s_ready_o
  );
endinterface

// File: rtl/piso_bit_timer.sv
// Bit-period timer: counts 0..div_i while enabled and ticks on the final count.
// Ports: clk/rst_n; clear_i forces the count to 0; en_i advances it; div_i is
//        the terminal count; tick_o is high in the last cycle of each bit period.
module piso_bit_timer #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  // Tick is combinational so the bit boundary lines up with the count that
  // hits the terminal value; the counter never has to wrap past div_i.
  assign tick_o = en_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with per-word bit order and bit period.
// Ports: clk/rst_n; s_bus word handshake (slave); serial_o registered data;
//        frame_o high while a word is on the wire; done_o last-cycle pulse.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  piso_serializer_if.slave     s_bus,
  output logic                 serial_o,
  output logic                 frame_o,
  output logic                 done_o
);

  localparam int BCW = bit_cnt_width(DATA_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  generate
    if (DATA_WIDTH < 2 || DATA_WIDTH > 255) begin : g_bad_width
      $error("piso_serializer: DATA_WIDTH must be within 2..255");
    end
  endgenerate

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  msb_q, msb_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  serial_q, serial_d;

  logic tick;
  logic last_tick;
  logic ready;
  logic accept;

  // Last cycle of the last bit: the only point inside a word where a new one
  // can be taken, which is what makes back-to-back words gap-free.
  assign last_tick = (state_q == SHIFT) && tick && (bit_cnt_q == LAST_BIT);

  // Ready depends only on state and counters, never on s_valid_i.
  assign ready  = (state_q == IDLE) || last_tick;
  assign accept = s_bus.s_valid_i && ready;

  assign s_bus.s_ready_o = ready;
  assign serial_o        = serial_q;
  assign frame_o         = (state_q == SHIFT);

  piso_bit_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (accept),
    .en_i    (state_q == SHIFT),
    .div_i   (div_q),
    .tick_o  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    msb_d     = msb_q;
    div_d     = div_q;
    serial_d  = serial_q;
    done_o    = last_tick;

    if (accept) begin
      // Order and period are captured here and held for the whole word.
      state_d   = SHIFT;
      shift_d   = s_bus.s_data_i;
      msb_d     = s_bus.msb_first_i;
      div_d     = s_bus.clk_div_i;
      bit_cnt_d = '0;
      serial_d  = s_bus.msb_first_i ? s_bus.s_data_i[DATA_WIDTH-1]
                                    : s_bus.s_data_i[0];
    end else if (last_tick) begin
      state_d   = IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
      serial_d  = 1'b0;
    end else if ((state_q == SHIFT) && tick) begin
      // The bit on the wire always sits at the outgoing end of shift_q.
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (msb_q) begin
        shift_d  = shift_q << 1;
        serial_d = shift_q[DATA_WIDTH-2];
      end else begin
        shift_d  = shift_q >> 1;
        serial_d = shift_q[1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      msb_q     <= 1'b0;
      div_q     <= '0;
      serial_q  <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      msb_q     <= msb_d;
      div_q     <= div_d;
      serial_q  <= serial_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed testbench for piso_serializer (DATA_WIDTH=16, DIV_WIDTH=8).
// Cycle k = k-th cycle after an accept edge, sampled on the falling edge.
module tb_piso_serializer;

  logic clk;
  logic rst_n;
  logic serial_o;
  logic frame_o;
  logic done_o;

  int n_vec;
  int n_err;

  logic ser [0:63];
  logic frm [0:63];
  logic dn  [0:63];
  logic rdy [0:63];

  piso_serializer_if #(.DATA_WIDTH(16), .DIV_WIDTH(8)) bus ();

  piso_serializer #(
    .DATA_WIDTH (16),
    .DIV_WIDTH  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_bus    (bus),
    .serial_o (serial_o),
    .frame_o  (frame_o),
    .done_o   (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a word one cycle after a rising edge and return just after the
  // accept edge. valid stays high; the caller decides when to drop it.
  task automatic start_word(input string tag, input logic [15:0] data,
                            input logic msb, input logic [7:0] div);
    @(posedge clk);
    #1;
    bus.s_valid_i   = 1'b1;
    bus.s_data_i    = data;
    bus.msb_first_i = msb;
    bus.clk_div_i   = div;
    check_val({tag, "_ready_idle"}, {31'd0, bus.s_ready_o}, 32'd1);
    @(posedge clk);
  endtask

  // Record ncyc cycles. Optional pokes after sampling cycle poke_at:
  // kind 1 = change order/period mid-word, kind 2 = one-cycle stall pulse.
  task automatic capture(input int ncyc, input int drop_at,
                         input int poke_at, input int poke_kind);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      ser[k] = serial_o;
      frm[k] = frame_o;
      dn[k]  = done_o;
      rdy[k] = bus.s_ready_o;
      if (k == drop_at) bus.s_valid_i = 1'b0;
      if (k == poke_at && poke_kind == 1) begin
        bus.clk_div_i   = 8'd7;
        bus.msb_first_i = ~bus.msb_first_i;
      end
      if (k == poke_at && poke_kind == 2) begin
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 16'hFFFF;
      end
      if (k == poke_at + 1 && poke_kind == 2) bus.s_valid_i = 1'b0;
    end
  endtask

  // exp_seq: bits in wire order, first bit on the left (bit 15).
  task automatic check_word(input string tag, input logic [15:0] exp_seq, input int div);
    int p;
    int len;
    int held_bad;
    int frame_cnt;
    int done_cnt;
    int done_at;
    int rdy_at;
    logic [15:0] obs;
    p = div + 1;
    len = 16 * p;
    held_bad = 0;
    frame_cnt = 0;
    done_cnt = 0;
    done_at = 0;
    rdy_at = 0;
    obs = '0;
    for (int j = 0; j < 16; j++) begin
      obs = {obs[14:0], ser[j*p+1]};
      for (int c = 1; c < p; c++)
        if (ser[j*p+1+c] !== ser[j*p+1]) held_bad++;
    end
    for (int k = 1; k <= len + 2; k++) begin
      if (frm[k] === 1'b1) frame_cnt++;
      if (dn[k] === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (rdy[k] === 1'b1 && rdy_at == 0) rdy_at = k;
    end
    check_val({tag, "_seq"},       {16'd0, obs}, {16'd0, exp_seq});
    check_val({tag, "_held"},      held_bad,     0);
    check_val({tag, "_frame_cnt"}, frame_cnt,    len);
    check_val({tag, "_done_cnt"},  done_cnt,     1);
    check_val({tag, "_done_at"},   done_at,      len);
    check_val({tag, "_ready_at"},  rdy_at,       len);
    check_val({tag, "_idle_frm"},  {31'd0, frm[len+1]}, 32'd0);
    check_val({tag, "_idle_ser"},  {31'd0, ser[len+1]}, 32'd0);
  endtask

  initial begin
    int ones;
    int frame_cnt;
    int done_cnt;
    n_vec = 0;
    n_err = 0;
    bus.s_valid_i   = 1'b0;
    bus.s_data_i    = '0;
    bus.msb_first_i = 1'b0;
    bus.clk_div_i   = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_serial", {31'd0, serial_o}, 32'd0);
    check_val("rst_frame",  {31'd0, frame_o},  32'd0);
    check_val("rst_done",   {31'd0, done_o},   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_ready", {31'd0, bus.s_ready_o}, 32'd1);

    // LSB-first, one bit per cycle: A5C3 -> 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
    start_word("lsb", 16'hA5C3, 1'b0, 8'd0);
    capture(19, 1, 0, 0);
    check_word("lsb", 16'b1100_0011_1010_0101, 0);

    // MSB-first, three cycles per bit: 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1
    start_word("msb", 16'hA5C3, 1'b1, 8'd2);
    capture(51, 1, 0, 0);
    check_word("msb", 16'b1010_0101_1100_0011, 2);

    // Back-to-back: 0001 then 8000, LSB-first -> ones at cycles 1 and 32.
    start_word("b2b", 16'h0001, 1'b0, 8'd0);
    #1 bus.s_data_i = 16'h8000;
    capture(36, 17, 0, 0);
    ones = 0;
    frame_cnt = 0;
    done_cnt = 0;
    for (int k = 1; k <= 36; k++) begin
      if (ser[k] === 1'b1) ones++;
      if (frm[k] === 1'b1) frame_cnt++;
      if (dn[k] === 1'b1) done_cnt++;
    end
    check_val("b2b_ones",      ones,      2);
    check_val("b2b_ser1",      {31'd0, ser[1]},  32'd1);
    check_val("b2b_ser32",     {31'd0, ser[32]}, 32'd1);
    check_val("b2b_frame_cnt", frame_cnt, 32);
    check_val("b2b_frm32",     {31'd0, frm[32]}, 32'd1);
    check_val("b2b_frm33",     {31'd0, frm[33]}, 32'd0);
    check_val("b2b_done16",    {31'd0, dn[16]},  32'd1);
    check_val("b2b_done32",    {31'd0, dn[32]},  32'd1);
    check_val("b2b_done_cnt",  done_cnt,  2);

    // Mid-word order/period change is ignored: 0F35 LSB-first.
    start_word("cfg", 16'h0F35, 1'b0, 8'd0);
    capture(19, 1, 3, 1);
    check_word("cfg", 16'b1010_1100_1111_0000, 0);

    // Stall pulse while busy is ignored: 1234 LSB-first.
    start_word("stall", 16'h1234, 1'b0, 8'd0);
    capture(19, 1, 5, 2);
    check_word("stall", 16'b0010_1100_0100_1000, 0);

    // Reset while bit 5 of 00E0 is on the wire.
    start_word("rstmid", 16'h00E0, 1'b0, 8'd0);
    #1 bus.s_valid_i = 1'b0;
    repeat (6) @(negedge clk);
    check_val("rstmid_bit5", {31'd0, serial_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rstmid_serial", {31'd0, serial_o}, 32'd0);
    check_val("rstmid_frame",  {31'd0, frame_o},  32'd0);
    check_val("rstmid_done",   {31'd0, done_o},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rstmid_ready", {31'd0, bus.s_ready_o}, 32'd1);

    // Next word after reset: 8001 LSB-first, two cycles per bit.
    start_word("post", 16'h8001, 1'b0, 8'd1);
    capture(35, 1, 0, 0);
    check_word("post", 16'b1000_0000_0000_0001, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out serializer.
- Accepts words over a valid/ready handshake and shifts them out one bit at a time.
- Bit order is selectable per word; bit period is programmable.
- Supports gap-free back-to-back words. Sits between a word-producing datapath and a single-wire serial link.

Parameters:
- DATA_WIDTH, 16, word width in bits; legal range 2..255; elaboration error outside it.
- DIV_WIDTH, 8, width of the bit-period divider input.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- s_valid_i  input  1  word-valid from producer.
- s_ready_o  output  1  serializer can accept a word this cycle.
- s_data_i  input  DATA_WIDTH  word to serialize.
- msb_first_i  input  1  bit order for the word: 1 = MSB first, 0 = LSB first. Sampled on accept.
- clk_div_i  input  DIV_WIDTH  each bit is held for clk_div_i+1 cycles. Sampled on accept.
- serial_o  output  1  serial data, registered.
- frame_o  output  1  high while a word's bits are on serial_o.
- done_o  output  1  one-cycle pulse in the final cycle of a word's last bit.

Behaviour:
- Reset (async assert, sync deassert by rst_n edge):
  - state=IDLE; shift register, bit counter and divider counter = 0.
  - serial_o=0, frame_o=0, done_o=0; s_ready_o=1 once rst_n is high.
  - Asserting rst_n mid-word discards the word immediately; serial_o drops to 0 with no further bits.
- Accept: handshake completes on a posedge where s_valid_i && s_ready_o.
  - On that edge: s_data_i, msb_first_i and clk_div_i are latched.
  - bit_cnt=0, div_cnt=0, state=SHIFT.
- Latency: first bit appears on serial_o in the cycle after the accept edge, with frame_o=1 in the same cycle.
- Bit period:
  - div_cnt counts 0..div_q; at div_cnt==div_q a bit tick occurs, div_cnt returns to 0 and the next bit is presented.
  - clk_div_i=0 gives one bit per cycle.
  - Changes to clk_div_i or msb_first_i mid-word are ignored.
- Order:
  - LSB-first presents bits 0,1,..,DATA_WIDTH-1 (shift right).
  - MSB-first presents bits DATA_WIDTH-1..0 (shift left).
- Word length is exactly DATA_WIDTH*(div_q+1) cycles of frame_o=1.
- Last cycle of the last bit (bit_cnt==DATA_WIDTH-1 and div_cnt==div_q):
  - done_o=1 and s_ready_o=1.
  - If s_valid_i=1 in that cycle, the new word is accepted and its first bit follows on the next cycle. frame_o stays 1 and there are no idle cycles.
  - Otherwise state=IDLE next cycle; serial_o=0, frame_o=0.
- s_ready_o:
  - =1 in IDLE or in the last cycle above; 0 otherwise.
  - Combinational from state and counters only, never from s_valid_i.
- s_valid_i while s_ready_o=0 is ignored. The producer must hold data stable until accepted.
- Counter widths:
  - bit_cnt is $clog2(DATA_WIDTH) bits.
  - div_cnt is DIV_WIDTH bits; it does not wrap before div_q is reached.
- States: IDLE → SHIFT on accept. SHIFT → SHIFT on back-to-back accept. SHIFT → IDLE on last tick without valid.

Decomposition:
- Package piso_pkg holds:
  - state typedef enum logic {IDLE, SHIFT}.
  - localparam helper function for the bit-counter width.
- Sub-module piso_bit_timer: DIV_WIDTH-wide counter with inputs clear, enable and div value; output tick. Instantiated once.
- Shift register, bit counter and FSM remain in piso_serializer.

Test Plan:
- DATA_WIDTH=16, LSB-first, div=0, data 16'hA5C3 → starting one cycle after accept, serial_o = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. frame_o high for exactly 16 cycles; done_o pulses on cycle 16.
- Same data, MSB-first, div=2 → serial_o = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, each bit held 3 cycles. frame_o high for 48 cycles; s_ready_o low until cycle 48.
- Back-to-back: s_valid_i held high with 16'h0001 then 16'h8000, LSB-first, div=0 → 32 contiguous frame_o cycles. serial_o=1 at cycles 1 and 32 only; done_o pulses at 16 and 32.
- Mid-word changes: toggle clk_div_i to 7 and msb_first_i during a div=0 LSB-first word → output identical to the unperturbed word.
- Reset at bit 5 of a word → serial_o, frame_o and done_o are 0 in the same cycle. s_ready_o=1 after release; the next accepted word serializes correctly from bit 0.
- Stall: s_valid_i pulsed while s_ready_o=0 → word not accepted; no change to the serial stream or frame_o.
